// File: rtl/inst_stream_decoder_pkg.sv
// Shared constants for the instruction-stream decoder: character codes, ASCII
// offsets and FSM state encoding.
package inst_stream_decoder_pkg;

  localparam logic [4:0] CODE_SPACE = 5'd0;
  localparam logic [4:0] CODE_A     = 5'd1;
  localparam logic [4:0] CODE_MAX   = 5'd26;

  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_LETTER_BASE = 8'h40;

  typedef enum logic [1:0] {
    StIdle,
    StWord,
    StGap,
    StDone
  } state_e;

  function automatic logic code_is_letter(input logic [4:0] code);
    return (code >= CODE_A) && (code <= CODE_MAX);
  endfunction

endpackage

// File: rtl/inst_char_fifo.sv
// First-word-fall-through character FIFO, DEPTH x 8, with count-based full/empty
// and a sticky overflow flag for dropped pushes.
module inst_char_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       sec_clock,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       valid_o,
  output logic       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FullCnt = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop     = pop_i && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push    = push_i && ((count_q != FullCnt) || do_pop);
    wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(do_push) - CW'(do_pop);
    overflow_d = overflow_q | (push_i & ~do_push);
  end

  always_ff @(posedge sec_clock) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge sec_clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign valid_o    = (count_q != '0);
  assign overflow_o = overflow_q;

endmodule

// File: rtl/inst_stream_decoder.sv
// Decodes a scrolling 8-character window into a character FIFO, counting words
// per message. Define INST_STREAM_DECODER_ASCII_EN to emit ASCII instead of raw codes.
module inst_stream_decoder
  import inst_stream_decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        sec_clock,
  input  logic        rst,
  input  logic [39:0] instruction,
  input  logic        rd_en,
  output logic [7:0]  char_data,
  output logic        char_valid,
  output logic [3:0]  word_count,
  output logic        msg_done,
  output logic        sync_err,
  output logic        overflow
);

  logic [39:0] prev_q, prev_d;
  state_e      state_q, state_d;
  logic [3:0]  word_count_q, word_count_d;
  logic        sync_err_q, sync_err_d;
  logic [4:0]  new_code;
  logic        is_hold, is_shift, is_letter, is_space;
  logic        shift_letter, shift_space, resync;
  logic        push;
  logic [7:0]  push_data;

  always_comb begin
    prev_d       = instruction;
    new_code     = instruction[4:0];
    is_hold      = (instruction == prev_q);
    is_shift     = (instruction[39:5] == prev_q[34:0]);
    is_letter    = code_is_letter(new_code);
    is_space     = (new_code == CODE_SPACE);
    shift_letter = !is_hold && is_shift && is_letter;
    shift_space  = !is_hold && is_shift && is_space;
    // Invalid codes on a shift fall through to resync as well.
    resync       = !is_hold && !shift_letter && !shift_space;

    state_d      = state_q;
    word_count_d = word_count_q;
    sync_err_d   = 1'b0;
    push         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (shift_letter) begin
          state_d      = StWord;
          word_count_d = 4'd1;
          push         = 1'b1;
        end
      end
      StWord: begin
        if (shift_letter) begin
          push = 1'b1;
        end else if (shift_space) begin
          state_d = StGap;
          push    = 1'b1;
        end else if (is_hold) begin
          state_d = StDone;
        end
      end
      StGap: begin
        if (shift_letter) begin
          state_d      = StWord;
          word_count_d = (word_count_q != 4'd15) ? word_count_q + 4'd1 : word_count_q;
          push         = 1'b1;
        end else if (is_hold) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // The DONE cycle ignores its input event entirely, including a resync.
    if (resync && (state_q != StDone)) begin
      sync_err_d   = 1'b1;
      state_d      = StIdle;
      word_count_d = word_count_q;
      push         = 1'b0;
    end
  end

`ifdef INST_STREAM_DECODER_ASCII_EN
  always_comb begin
    push_data = is_space ? ASCII_SPACE : ASCII_LETTER_BASE + {3'b000, new_code};
  end
`else
  always_comb begin
    push_data = {3'b000, new_code};
  end
`endif

  always_ff @(posedge sec_clock) begin
    if (rst) begin
      prev_q       <= '0;
      state_q      <= StIdle;
      word_count_q <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      state_q      <= state_d;
      word_count_q <= word_count_d;
      sync_err_q   <= sync_err_d;
    end
  end

  inst_char_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .sec_clock  (sec_clock),
    .rst        (rst),
    .push_i     (push),
    .pop_i      (rd_en),
    .wdata_i    (push_data),
    .rdata_o    (char_data),
    .valid_o    (char_valid),
    .overflow_o (overflow)
  );

  assign word_count = word_count_q;
  assign msg_done   = (state_q == StDone);
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_inst_stream_decoder.sv
// Randomized and directed bench for inst_stream_decoder against a text-level
// model of message/word parsing and a queue-based FIFO.
module tb_inst_stream_decoder;

  localparam int DEPTH = 16;

  logic        sec_clock;
  logic        rst;
  logic [39:0] instruction;
  logic        rd_en;
  logic [7:0]  char_data;
  logic        char_valid;
  logic [3:0]  word_count;
  logic        msg_done;
  logic        sync_err;
  logic        overflow;

  inst_stream_decoder #(
    .DEPTH(DEPTH)
  ) dut (
    .sec_clock   (sec_clock),
    .rst         (rst),
    .instruction (instruction),
    .rd_en       (rd_en),
    .char_data   (char_data),
    .char_valid  (char_valid),
    .word_count  (word_count),
    .msg_done    (msg_done),
    .sync_err    (sync_err),
    .overflow    (overflow)
  );

  initial sec_clock = 1'b0;
  always #5 sec_clock = ~sec_clock;

  int n_checks = 0;
  int n_errors = 0;
  int n_msg    = 0;
  int n_serr   = 0;

  logic [39:0] win;
  logic [7:0]  obs_q[$];

  // Reference model state
  logic [39:0] m_prev;
  bit          m_in_msg, m_last_space, m_ending, m_ovf, m_serr;
  int          m_wc;
  logic [7:0]  m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_char(input int code);
`ifdef INST_STREAM_DECODER_ASCII_EN
    return (code == 0) ? 8'h20 : 8'(8'h40 + code);
`else
    return 8'(code);
`endif
  endfunction

  function automatic int code_of(input byte c);
    return (c == " ") ? 0 : int'(c) - 64;
  endfunction

  task automatic model_step();
    bit hold, shift, did_pop, push_req;
    int code;
    if (rst) begin
      m_prev = '0; m_in_msg = 0; m_last_space = 0; m_ending = 0;
      m_ovf = 0; m_serr = 0; m_wc = 0; m_q.delete();
      return;
    end
    hold     = (instruction == m_prev);
    shift    = (instruction[39:5] == m_prev[34:0]);
    code     = int'(instruction[4:0]);
    did_pop  = rd_en && (m_q.size() > 0);
    push_req = 0;
    m_serr   = 0;
    if (m_ending) begin
      m_ending = 0;
    end else if (hold) begin
      if (m_in_msg) begin
        m_ending = 1;
        m_in_msg = 0;
      end
    end else if (!shift || code > 26) begin
      m_serr   = 1;
      m_in_msg = 0;
    end else if (code == 0) begin
      if (m_in_msg && !m_last_space) begin
        push_req     = 1;
        m_last_space = 1;
      end
    end else begin
      if (!m_in_msg) begin
        m_in_msg = 1;
        m_wc     = 1;
      end else if (m_last_space) begin
        m_wc = (m_wc < 15) ? m_wc + 1 : 15;
      end
      m_last_space = 0;
      push_req     = 1;
    end
    if (did_pop) void'(m_q.pop_front());
    if (push_req) begin
      if (m_q.size() < DEPTH) m_q.push_back(exp_char(code));
      else m_ovf = 1;
    end
    m_prev = instruction;
  endtask

  task automatic compare_all();
    check_eq("char_valid", char_valid, m_q.size() != 0);
    if (m_q.size() != 0) check_eq("char_data", char_data, m_q[0]);
    check_eq("word_count", word_count, m_wc);
    check_eq("msg_done", msg_done, m_ending);
    check_eq("sync_err", sync_err, m_serr);
    check_eq("overflow", overflow, m_ovf);
  endtask

  task automatic tick();
    if (!rst && rd_en && char_valid) obs_q.push_back(char_data);
    @(posedge sec_clock);
    model_step();
    #1;
    compare_all();
    if (msg_done) n_msg++;
    if (sync_err) n_serr++;
  endtask

  task automatic do_reset();
    rst = 1'b1; win = '0; instruction = '0; rd_en = 1'b0;
    tick();
    rst = 1'b0;
    n_msg = 0; n_serr = 0; obs_q.delete();
  endtask

  task automatic shift_in(input int code, input bit rd);
    win = {win[34:0], 5'(code)};
    instruction = win;
    rd_en = rd;
    tick();
  endtask

  task automatic hold_cycles(input int n, input bit rd);
    rd_en = rd;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic scroll(input string s, input int pad, input bit rd);
    for (int i = 0; i < s.len(); i++) shift_in(code_of(s[i]), rd);
    for (int i = 0; i < pad; i++) shift_in(0, rd);
  endtask

  task automatic check_obs(input string tag, input string s);
    check_eq({tag, "_len"}, obs_q.size(), s.len());
    for (int i = 0; i < s.len() && i < obs_q.size(); i++)
      check_eq(tag, obs_q[i], exp_char(code_of(s[i])));
  endtask

  initial begin
    int rd_pct;
    int r;
    rst = 1'b1; win = '0; instruction = '0; rd_en = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_valid", char_valid, 0);
    check_eq("rst_wc", word_count, 0);
    check_eq("rst_ovf", overflow, 0);

    // Full scroll, consumer always reading
    scroll("INPUT ACCOUNT NUMBER", 8, 1'b1);
    hold_cycles(3, 1'b1);
    check_obs("scroll_bytes", "INPUT ACCOUNT NUMBER ");
    check_eq("scroll_msg_pulses", n_msg, 1);
    check_eq("scroll_serr", n_serr, 0);
    check_eq("scroll_wc", word_count, 3);

    // Same scroll with no consumer: overflow after 16 entries
    do_reset();
    scroll("INPUT ACCOUNT NUMBER", 8, 1'b0);
    hold_cycles(2, 1'b0);
    check_eq("ovf_set", overflow, 1);
    obs_q.delete();
    hold_cycles(18, 1'b1);
    check_obs("ovf_bytes", "INPUT ACCOUNT NU");

    // Window jump is a resync
    do_reset();
    shift_in(9, 1'b0);
    win = 40'h00000003E0; instruction = win; tick();
    check_eq("jump_serr", sync_err, 1);
    check_eq("jump_head", char_data, exp_char(9));
    tick();
    check_eq("jump_serr_clr", sync_err, 0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) shift_in(i + 1, 1'b0);
    shift_in(20, 1'b1);
    check_eq("fullpp_ovf", overflow, 0);
    check_eq("fullpp_head", char_data, exp_char(2));

    // Reset mid-message
    do_reset();
    scroll("ACC", 0, 1'b0);
    rst = 1'b1; win = '0; instruction = '0; tick();
    check_eq("midrst_valid", char_valid, 0);
    check_eq("midrst_wc", word_count, 0);
    rst = 1'b0; obs_q.delete();
    scroll("NUM", 0, 1'b0);
    hold_cycles(5, 1'b1);
    check_obs("midrst_bytes", "NUM");
    check_eq("midrst_wc1", word_count, 1);

    // Raw code path for letter A
    do_reset();
    shift_in(1, 1'b0);
    check_eq("code_a", char_data, exp_char(1));

    // Randomized traffic
    do_reset();
    rd_pct = 80;
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) rd_pct = (rd_pct == 80) ? 15 : ((rd_pct == 15) ? 55 : 80);
      rd_en = ($urandom_range(0, 99) < rd_pct);
      r = $urandom_range(0, 99);
      if (r < 1) begin
        rst = 1'b1; win = '0; instruction = '0; tick(); rst = 1'b0;
      end else if (r < 15) begin
        tick();
      end else if (r < 19) begin
        win = {8'($urandom), 32'($urandom)}; instruction = win; tick();
      end else if (r < 22) begin
        win = {win[34:0], 5'($urandom_range(27, 31))}; instruction = win; tick();
      end else if (r < 45) begin
        win = {win[34:0], 5'd0}; instruction = win; tick();
      end else begin
        win = {win[34:0], 5'($urandom_range(1, 26))}; instruction = win; tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_stream_decoder.md
INST_STREAM_DECODER -- requirements
Module: inst_stream_decoder

Interface
REQ-001 Parameter DEPTH, default 16: character FIFO depth in entries, power of two, 4 to 64.
REQ-002 sec_clock  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset: synchronous, active-high, sampled on sec_clock.
REQ-004 instruction  input  40  8-character scrolling window; 5-bit codes, newest character in [4:0], oldest in [39:35].
REQ-005 rd_en  input  1  consumer pop request for the FIFO head.
REQ-006 char_data  output  8  FIFO head character; valid only while char_valid=1.
REQ-007 char_valid  output  1  FIFO non-empty.
REQ-008 word_count  output  4  number of words in the current or last message; saturates at 15.
REQ-009 msg_done  output  1  one-cycle pulse marking the end of a message.
REQ-010 sync_err  output  1  one-cycle pulse when a window change is neither a hold nor a single shift.
REQ-011 overflow  output  1  sticky flag: a push was dropped because the FIFO was full.

Function
REQ-012 Register prev (40 bits) SHALL capture instruction every cycle; each cycle is classified against prev in this priority order: HOLD (instruction==prev), SHIFT (instruction[39:5]==prev[34:0]; new code = instruction[4:0]), else RESYNC.
REQ-013 Code map SHALL be: 0 = space, 1..26 = A..Z, 27..31 = invalid.
REQ-014 The FSM SHALL have states IDLE, WORD, GAP and DONE.
REQ-015 IDLE: SHIFT with a letter -> WORD, word_count<=1, push letter; SHIFT with a space -> stay in IDLE, no push.
REQ-016 WORD: letter -> push; space -> GAP, push one space; HOLD -> DONE.
REQ-017 GAP: space -> no push (runs of spaces collapse to one); letter -> WORD, word_count+1 (saturating), push letter; HOLD -> DONE.
REQ-018 DONE SHALL assert msg_done for exactly that cycle, then go to IDLE unconditionally; an input event in the DONE cycle is classified but ignored.
REQ-019 RESYNC in any state SHALL pulse sync_err, go to IDLE and leave the FIFO and word_count unchanged; an invalid code (27..31) on SHIFT is treated as RESYNC.
REQ-020 Latency: a character entering instruction[4:0] before edge N SHALL be pushed at edge N and visible with char_valid=1 after edge N.
REQ-021 The FIFO SHALL be first-word-fall-through: rd_en with char_valid=1 pops at the edge; rd_en on an empty FIFO is ignored.
REQ-022 A simultaneous push and pop SHALL both succeed, including when the FIFO is full.
REQ-023 A push to a full FIFO without a pop SHALL be dropped and SHALL set overflow.
REQ-024 word_count SHALL hold its value through DONE and IDLE until the first letter of the next message.

Reset
REQ-025 rst SHALL clear prev to 0, set the FSM to IDLE, empty the FIFO, and drive char_valid, word_count, msg_done, sync_err and overflow to 0; char_data is don't-care.
REQ-026 rst asserted mid-message SHALL discard all partial state; the first edge after reset compares against prev=0.

Configuration
REQ-027 Macro INST_STREAM_DECODER_ASCII_EN defined: char_data is ASCII (letters 0x41..0x5A, space 0x20).
REQ-028 Macro INST_STREAM_DECODER_ASCII_EN undefined: char_data = {3'b000, code}; the decode logic is absent.

Structure
REQ-029 A shared package SHALL hold the code constants (CODE_SPACE=0, CODE_A=1, CODE_MAX=26), the FSM state encoding, and the ASCII offset constants.
REQ-030 The FIFO SHALL be one sub-module, inst_char_fifo (DEPTH x 8, FWFT, count-based full/empty).

Verification
REQ-031 Drive the full 28-cycle "INPUT ACCOUNT NUMBER" scroll with rd_en=1 and ASCII_EN defined -> popped bytes "INPUT ACCOUNT NUMBER " (21 bytes); msg_done pulses once, on the first hold after the trailing spaces; word_count=3; sync_err=0.
REQ-032 Same stream with rd_en=0 and DEPTH=16 -> 16 entries ("INPUT ACCOUNT NU") stored, overflow=1 from the 17th push onward.
REQ-033 Window jumps from 0x0000000009 to 0x00000003E0 -> sync_err pulses 1 cycle, state IDLE, FIFO contents unchanged.
REQ-034 FIFO full with a push and rd_en in the same cycle -> count stays 16, overflow stays 0, head advances by one.
REQ-035 rst asserted after "ACC" -> char_valid=0 and word_count=0 next cycle; a following "NUM" stream yields exactly "NUM", word_count=1.
REQ-036 ASCII_EN undefined, shift code 5'b00001 -> char_data=8'h01.
